cga_mac_dram_seq: RTL and testbench



---
 rtl/cga_mac_dram_seq.sv | 145 ++++++++++++++
 tb/tb_cga_mac_dram_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_mac_dram_seq.sv
// DRAM access sequencer for the MAC address path: RAS/CAS access cycles with
// a multiplexed row/column address, plus periodic CAS-before-RAS refresh.
module cga_mac_dram_seq #(
  parameter int unsigned T_RCD            = 2,
  parameter int unsigned T_CAS            = 2,
  parameter int unsigned T_RP             = 2,
  parameter int unsigned T_REF            = 3,
  parameter int unsigned REFRESH_INTERVAL = 390
) (
  input  logic        sysclk,
  input  logic        sys_rst_n,
  input  logic        REQ,
  input  logic        WRITE,
  input  logic [19:0] MA_19_0,
  output logic        ACK,
  output logic        BUSY,
  output logic        REFPEND,
  output logic [9:0]  DRA_9_0,
  output logic        RAS_N,
  output logic        CAS_N,
  output logic        WE_N
);

  localparam int unsigned T_MAX_A = (T_RCD > T_CAS) ? T_RCD : T_CAS;
  localparam int unsigned T_MAX_B = (T_RP > T_REF) ? T_RP : T_REF;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned PH_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int unsigned REF_W   = $clog2(REFRESH_INTERVAL);

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    PRE,
    RCAS,
    RRAS
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [REF_W-1:0]  ref_cnt;
  logic              ref_expire;
  logic [19:0]       addr_q;
  logic              wr_q;

  assign ref_expire = (ref_cnt == '0);

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ref_cnt <= REF_W'(REFRESH_INTERVAL - 1);
    end else if (ref_expire) begin
      ref_cnt <= REF_W'(REFRESH_INTERVAL - 1);
    end else begin
      ref_cnt <= ref_cnt - REF_W'(1);
    end
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      phase   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      ACK     <= 1'b0;
      BUSY    <= 1'b0;
      REFPEND <= 1'b0;
      DRA_9_0 <= '0;
      RAS_N   <= 1'b1;
      CAS_N   <= 1'b1;
      WE_N    <= 1'b1;
    end else begin
      ACK <= 1'b0;
      if (ref_expire) REFPEND <= 1'b1;
      unique case (state)
        IDLE: begin
          if (REFPEND) begin
            // an expiry landing on the clearing edge keeps the flag set
            state   <= RCAS;
            REFPEND <= ref_expire;
            CAS_N   <= 1'b0;
            BUSY    <= 1'b1;
          end else if (REQ) begin
            state   <= ROW;
            addr_q  <= MA_19_0;
            wr_q    <= WRITE;
            DRA_9_0 <= MA_19_0[19:10];
            RAS_N   <= 1'b0;
            BUSY    <= 1'b1;
            phase   <= PH_W'(T_RCD - 1);
          end
        end
        ROW: begin
          if (phase == '0) begin
            state   <= COL;
            CAS_N   <= 1'b0;
            DRA_9_0 <= addr_q[9:0];
            WE_N    <= ~wr_q;
            phase   <= PH_W'(T_CAS - 1);
            ACK     <= (T_CAS == 1);
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        COL: begin
          if (phase == '0) begin
            state <= PRE;
            RAS_N <= 1'b1;
            CAS_N <= 1'b1;
            WE_N  <= 1'b1;
            phase <= PH_W'(T_RP - 1);
          end else begin
            // ACK is registered, so raise it one cycle ahead of the last COL cycle
            ACK   <= (phase == PH_W'(1));
            phase <= phase - PH_W'(1);
          end
        end
        PRE: begin
          if (phase == '0) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        RCAS: begin
          state <= RRAS;
          RAS_N <= 1'b0;
          phase <= PH_W'(T_REF - 1);
        end
        RRAS: begin
          if (phase == '0) begin
            state <= PRE;
            RAS_N <= 1'b1;
            CAS_N <= 1'b1;
            phase <= PH_W'(T_RP - 1);
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cga_mac_dram_seq.sv
// Directed bench for cga_mac_dram_seq: access timing, back-to-back, refresh
// scheduling and priority, asynchronous reset during an access.
module tb_cga_mac_dram_seq;

  logic        clk;
  logic        rst_n;
  logic        req, wr;
  logic [19:0] ma;
  logic        ack, busy, refpend, ras_n, cas_n, we_n;
  logic [9:0]  dra;
  logic        req_r, wr_r;
  logic [19:0] ma_r;
  logic        ack_r, busy_r, refpend_r, ras_n_r, cas_n_r, we_n_r;
  logic [9:0]  dra_r;

  int checks = 0;
  int errors = 0;

  cga_mac_dram_seq dut (
    .sysclk(clk), .sys_rst_n(rst_n), .REQ(req), .WRITE(wr), .MA_19_0(ma),
    .ACK(ack), .BUSY(busy), .REFPEND(refpend), .DRA_9_0(dra),
    .RAS_N(ras_n), .CAS_N(cas_n), .WE_N(we_n)
  );

  cga_mac_dram_seq #(.REFRESH_INTERVAL(16)) dut_r (
    .sysclk(clk), .sys_rst_n(rst_n), .REQ(req_r), .WRITE(wr_r), .MA_19_0(ma_r),
    .ACK(ack_r), .BUSY(busy_r), .REFPEND(refpend_r), .DRA_9_0(dra_r),
    .RAS_N(ras_n_r), .CAS_N(cas_n_r), .WE_N(we_n_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // {RAS_N, CAS_N, WE_N, ACK, BUSY, DRA}
  function automatic logic [14:0] pk(input logic r, input logic c, input logic w,
                                     input logic a, input logic b, input logic [9:0] d);
    return {r, c, w, a, b, d};
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    req = 1'b0; wr = 1'b0; ma = '0;
    req_r = 1'b0; wr_r = 1'b0; ma_r = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [14:0] obs;
    rst_n = 1'b0;
    req = 1'b0; wr = 1'b0; ma = '0;
    req_r = 1'b0; wr_r = 1'b0; ma_r = '0;
    tick();
    obs = pk(ras_n, cas_n, we_n, ack, busy, dra);
    checks++;
    if (obs !== pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000)) begin
      errors++;
      $display("FAIL reset_outputs got %h expected %h", obs, pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000));
    end
    checks++;
    if (refpend !== 1'b0 || refpend_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_refpend got %b/%b expected 0/0", refpend, refpend_r);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_access(input logic [19:0] ma_v, input logic wr_v, input string nm);
    logic [14:0] obs, exp;
    logic [9:0]  row, col;
    int acks;
    row = ma_v[19:10];
    col = ma_v[9:0];
    acks = 0;
    do_reset();
    req = 1'b1; ma = ma_v; wr = wr_v;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) begin ma = ~ma_v; wr = ~wr_v; end
      if (i == 5) req = 1'b0;
      case (i)
        1, 2:    exp = pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, row);
        3, 4:    exp = pk(1'b0, 1'b0, ~wr_v, (i == 4), 1'b1, col);
        5, 6:    exp = pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, col);
        default: exp = pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, col);
      endcase
      obs = pk(ras_n, cas_n, we_n, ack, busy, dra);
      if (ack === 1'b1) acks++;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d got %h expected %h", nm, i, obs, exp);
      end
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL %s_ack_count got %0d expected 1", nm, acks);
    end
  endtask

  task automatic test_back_to_back;
    logic [14:0] obs, exp;
    logic [19:0] a, b;
    int acks;
    a = 20'h2A5F3;
    b = 20'h13C8E;
    acks = 0;
    do_reset();
    req = 1'b1; ma = a; wr = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 2) ma = b;
      if (i == 8) req = 1'b0;
      case (i)
        1, 2:    exp = pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a[19:10]);
        3, 4:    exp = pk(1'b0, 1'b0, 1'b1, (i == 4), 1'b1, a[9:0]);
        5, 6:    exp = pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, a[9:0]);
        7:       exp = pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, a[9:0]);
        8, 9:    exp = pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, b[19:10]);
        10, 11:  exp = pk(1'b0, 1'b0, 1'b1, (i == 11), 1'b1, b[9:0]);
        12, 13:  exp = pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, b[9:0]);
        default: exp = pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, b[9:0]);
      endcase
      obs = pk(ras_n, cas_n, we_n, ack, busy, dra);
      if (ack === 1'b1) acks++;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got %h expected %h", i, obs, exp);
      end
    end
    checks++;
    if (acks != 2) begin
      errors++;
      $display("FAIL back_to_back_ack_count got %0d expected 2", acks);
    end
  endtask

  // {REFPEND, RAS_N, CAS_N, WE_N, ACK, BUSY}
  task automatic test_refresh;
    logic [5:0] obs, exp;
    int m;
    do_reset();
    for (int k = 1; k <= 35; k++) begin
      tick();
      m = k % 16;
      if (k < 16) exp = 6'b011100;
      else case (m)
        0:          exp = 6'b111100;
        1:          exp = 6'b010101;
        2, 3, 4:    exp = 6'b000101;
        5, 6:       exp = 6'b011101;
        default:    exp = 6'b011100;
      endcase
      obs = {refpend_r, ras_n_r, cas_n_r, we_n_r, ack_r, busy_r};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL refresh cycle %0d got %b expected %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_refresh_priority;
    int acks, ack_at, cas_fall;
    acks = 0; ack_at = -1; cas_fall = -1;
    do_reset();
    for (int k = 1; k <= 16; k++) tick();
    checks++;
    if (refpend_r !== 1'b1 || busy_r !== 1'b0) begin
      errors++;
      $display("FAIL prio_refpend got refpend=%b busy=%b expected 1/0", refpend_r, busy_r);
    end
    req_r = 1'b1; ma_r = 20'h12345; wr_r = 1'b1;
    for (int k = 17; k <= 31; k++) begin
      tick();
      if (k == 28) req_r = 1'b0;
      if (cas_fall < 0 && cas_n_r === 1'b0) cas_fall = k;
      if (ack_r === 1'b1) begin acks++; ack_at = k; end
      if (k == 17) begin
        checks++;
        if ({ras_n_r, cas_n_r} !== 2'b10) begin
          errors++;
          $display("FAIL prio_refresh_first got ras/cas=%b%b expected 10", ras_n_r, cas_n_r);
        end
      end
      if (k == 24) begin
        checks++;
        if ({ras_n_r, cas_n_r, dra_r} !== {2'b01, 10'h048}) begin
          errors++;
          $display("FAIL prio_row got %b%b %h expected 01 048", ras_n_r, cas_n_r, dra_r);
        end
      end
      if (k == 27) begin
        checks++;
        if ({we_n_r, dra_r} !== {1'b0, 10'h345}) begin
          errors++;
          $display("FAIL prio_col got we=%b dra=%h expected 0 345", we_n_r, dra_r);
        end
      end
    end
    checks++;
    if (acks != 1 || cas_fall != 17 || ack_at - cas_fall != 10) begin
      errors++;
      $display("FAIL prio_ack_timing got acks=%0d cas_fall=%0d ack=%0d expected 1/17/27",
               acks, cas_fall, ack_at);
    end
  endtask

  task automatic test_reset_mid_access;
    int acks;
    acks = 0;
    do_reset();
    req = 1'b1; ma = 20'h55555; wr = 1'b1;
    for (int i = 1; i <= 3; i++) tick();
    req = 1'b0;
    checks++;
    if ({ras_n, cas_n, we_n} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_in_col got %b expected 000", {ras_n, cas_n, we_n});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ras_n, cas_n, we_n, ack, busy} !== 5'b11100) begin
      errors++;
      $display("FAIL midrst_async got %b expected 11100", {ras_n, cas_n, we_n, ack, busy});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0 || busy !== 1'b0 || ras_n !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle got acks=%0d busy=%b ras_n=%b expected 0/0/1", acks, busy, ras_n);
    end
    req = 1'b1; ma = 20'hABCDE; wr = 1'b0;
    tick();
    req = 1'b0;
    checks++;
    if ({ras_n, busy, dra} !== {2'b01, 10'h2AF}) begin
      errors++;
      $display("FAIL midrst_restart got %b%b %h expected 01 2af", ras_n, busy, dra);
    end
    for (int i = 1; i <= 8; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0; wr = 1'b0; ma = '0;
    req_r = 1'b0; wr_r = 1'b0; ma_r = '0;
    #2;
    test_reset();
    test_single_access(20'h2A5F3, 1'b0, "read");
    test_single_access(20'hFFFFF, 1'b1, "write");
    test_back_to_back();
    test_refresh();
    test_refresh_priority();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
